reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-file hazard scoreboard for the pipelined Y86-64 core. It tracks pending writes to each of the 15 architectural registers and stalls issue when an instruction reads a register with an outstanding write. Writebacks from the E and M ports retire those pending writes. It sits between fetch/decode issue and the register file, and gates when decode may read `reg_mem`. It also provides a drain sequence so the core can quiesce the register file before halt or debug.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter; max in-flight writes per register is 2^CNT_W−1.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode presents an instruction.
- `issue_ready`  out  1  scoreboard accepts it; fire = valid & ready.
- `srcA`, `srcB`  in  4  source register IDs; 4'hF = none.
- `dstE`, `dstM`  in  4  destination register IDs; 4'hF = none.
- `wbE_valid`, `wbM_valid`  in  1  writeback retire strobes.
- `wbE_reg`, `wbM_reg`  in  4  retired register IDs.
- `drain_req`  in  1  request quiesce (level, sampled in RUN).
- `drain_done`  out  1  one-cycle pulse when drain completes.
- `busy_mask`  out  15  bit i = register i has pending writes.
- `err`  out  1  sticky: retire to a register whose counter is 0.
- `stall_cnt`  out  16  stall-cycle counter (only with `SB_PERF_EN`).

## Operation
- State per register i (0..14): counter `cnt[i]`, CNT_W bits. ID 4'hF is never tracked.
- Hazard when srcA≠F with `cnt[srcA]`≠0, or srcB≠F with `cnt[srcB]`≠0.
- Saturation when a dst would exceed 2^CNT_W−1. dstE==dstM (not F) adds 2.
- `issue_ready` = (state==RUN) & !hazard & !saturation. It is combinational from the registered counters. There is no same-cycle bypass from wb strobes.
- On fire, increment `cnt[dstE]` and `cnt[dstM]` (each if ≠F).
- On a wb strobe with reg≠F, decrement that counter. wbE and wbM may target the same register: subtract 2.
- Net update per register = increments − decrements, applied in one cycle.
- A decrement below 0 clamps at 0 and sets `err`. `err` clears only on reset.
- FSM:
  - RUN → DRAIN when `drain_req`=1.
  - DRAIN: `issue_ready`=0; wb retires still apply. When all counters are 0 → DONE.
  - DONE: `drain_done`=1 for exactly one cycle → IDLE.
  - IDLE: hold until `drain_req`=0 → RUN.
- `busy_mask[i]` = (`cnt[i]`≠0), registered view.

## Timing
- Reset values: all counters 0, state RUN, `busy_mask`=0, `err`=0, `drain_done`=0, `stall_cnt`=0. `issue_ready`=1 if no source is pending.
- Issue to visible busy: 1 cycle. A dependent instruction stalls starting the cycle after fire.
- Retire to ready: 1 cycle. A wb in cycle N clears the hazard for issue in cycle N+1.
- Drain with counters already 0: RUN(N) → DRAIN(N+1) → DONE(N+2); `drain_done` high in cycle N+2.
- Reset asserted mid-drain or mid-stall: immediate return to the reset state. No pulse is generated.
- Fire and retire to the same register in one cycle: the counter is unchanged, and it remains busy if it was non-zero.

## Configuration
- `SB_PERF_EN` defined:
  - `stall_cnt` increments each cycle with `issue_valid` & !`issue_ready` & state==RUN.
  - It saturates at 16'hFFFF.
- Not defined: `stall_cnt` is tied to 0 and no counter logic is compiled.

## Structure
- Shared package `y86_pkg`: `RNONE`=4'hF, `NREG`=15, and the `sb_state_t` enum {RUN, DRAIN, DONE, IDLE}.
- Sub-module `sb_counter`: one per register.
  - Inputs: inc amount 0..2, dec amount 0..2.
  - Outputs: count, nonzero flag, saturation flag, underflow flag.
  - Instantiated 15 times via generate.

## Test plan
- After reset, issue irmovq (dstE=3): `busy_mask`=15'h0008 next cycle. Then issue an OPq with srcA=3 → `issue_ready`=0 until wbE_reg=3, then ready=1 the following cycle.
- popq with dstE=4, dstM=4: `cnt[4]`=2. A single wbE → still busy. A wbM the next cycle → `busy_mask[4]`=0.
- CNT_W=2: three issues writing r7 → fourth issue writing r7 gets `issue_ready`=0. One retire → ready again.
- wbE_reg=5 with `cnt[5]`=0 → `err`=1 stays set, counter stays 0.
- `drain_req` with `cnt[2]`=1: ready=0; wb r2 at cycle N → `drain_done` pulse at N+1 → IDLE. Deassert `drain_req` → RUN.
- `SB_PERF_EN`: 10 stalled valid cycles → `stall_cnt`=10. Without the macro it reads 0.

Source files
------------

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : y86_pkg
//  Brief    : Shared register-ID constants and scoreboard state encoding for
//             the pipelined Y86-64 core.
//  Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

   // Register ID meaning "no register"; never tracked by the scoreboard
   localparam logic [3:0] RNONE = 4'hF;

   // Number of architectural registers (IDs 0..14)
   localparam int NREG = 15;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2,
      IDLE  = 2'd3
   } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sb_counter
//  Brief    : Pending-write counter for one architectural register. Applies
//             the net of issue increments and writeback decrements each
//             cycle, clamping at zero on over-retire.
//  Revision : 1.0 - initial release
// ============================================================================
module sb_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       inc_req,    // writes this register would add (0..2)
   input  logic             inc_en,     // the instruction actually issues
   input  logic [1:0]       dec_amt,    // retires this cycle (0..2)
   output logic [CNT_W-1:0] count,
   output logic             nonzero,
   output logic             sat,        // issuing inc_req would overflow
   output logic             underflow,  // more retires than pending writes
   output logic             next_zero   // counter will be zero after this edge
);

   // Two guard bits hold cnt + 2 without wrap for any CNT_W
   localparam int                 EW        = CNT_W + 2;
   localparam logic [CNT_W+1:0]   c_cnt_max = EW'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] r_count;
   logic [1:0]       w_inc;
   logic [EW-1:0]    w_req_sum;
   logic [EW-1:0]    w_up;
   logic [EW-1:0]    w_dec;
   logic [CNT_W-1:0] w_next;

   assign w_inc     = inc_en ? inc_req : 2'd0;
   assign w_req_sum = EW'(r_count) + EW'(inc_req);
   assign w_up      = EW'(r_count) + EW'(w_inc);
   assign w_dec     = EW'(dec_amt);

   // Saturation looks at the requested writes, not the gated ones, so it can
   // feed issue_ready without a combinational loop through the fire signal
   assign sat       = (w_req_sum > c_cnt_max);
   assign underflow = (w_dec > w_up);
   assign w_next    = underflow ? '0 : CNT_W'(w_up - w_dec);

   assign count     = r_count;
   assign nonzero   = (r_count != '0);
   assign next_zero = (w_next == '0);

   // Pending-write count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Brief    : Register-file hazard scoreboard. Tracks pending writes per
//             architectural register, stalls issue on read-after-write
//             hazards or counter saturation, retires on E/M writebacks and
//             offers a drain handshake to quiesce before halt/debug.
//             Optional macro SB_PERF_EN adds a saturating stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard
   import y86_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [3:0]      srcA,
   input  logic [3:0]      srcB,
   input  logic [3:0]      dstE,
   input  logic [3:0]      dstM,
   input  logic            wbE_valid,
   input  logic [3:0]      wbE_reg,
   input  logic            wbM_valid,
   input  logic [3:0]      wbM_reg,
   input  logic            drain_req,
   output logic            drain_done,
   output logic [NREG-1:0] busy_mask,
   output logic            err,
   output logic [15:0]     stall_cnt
);

   sb_state_t       r_state;
   logic            r_drain_done;
   logic            r_err;
   logic [NREG-1:0] w_busy;
   logic [NREG-1:0] w_src_pend;
   logic [NREG-1:0] w_sat;
   logic [NREG-1:0] w_uflow;
   logic [NREG-1:0] w_next_zero;
   logic            w_fire;

   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [3:0] c_id = 4'(gi);

      logic [1:0]       w_inc_req;
      logic [1:0]       w_dec_amt;
      logic [CNT_W-1:0] w_cnt;

      // dstE==dstM on the same register counts as two writes; likewise for
      // both writeback ports retiring the same register
      assign w_inc_req = {1'b0, (dstE == c_id)} + {1'b0, (dstM == c_id)};
      assign w_dec_amt = {1'b0, (wbE_valid && (wbE_reg == c_id))}
                       + {1'b0, (wbM_valid && (wbM_reg == c_id))};

      // RNONE can never equal an index below NREG, so no explicit check
      assign w_src_pend[gi] = ((srcA == c_id) || (srcB == c_id)) && (w_cnt != '0);

      sb_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .inc_req   (w_inc_req),
         .inc_en    (w_fire),
         .dec_amt   (w_dec_amt),
         .count     (w_cnt),
         .nonzero   (w_busy[gi]),
         .sat       (w_sat[gi]),
         .underflow (w_uflow[gi]),
         .next_zero (w_next_zero[gi])
      );
   end

   // No writeback bypass: readiness depends only on registered counters
   assign issue_ready = (r_state == RUN) && !(|w_src_pend) && !(|w_sat);
   assign w_fire      = issue_valid && issue_ready;

   assign busy_mask   = w_busy;
   assign err         = r_err;
   assign drain_done  = r_drain_done;

   // Sticky over-retire flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (|w_uflow) begin
         r_err <= 1'b1;
      end
   end

   // Drain sequencer; DONE lasts one cycle so drain_done is a single pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_drain_done <= 1'b0;
      end else begin
         r_drain_done <= 1'b0;
         case (r_state)
            RUN: begin
               if (drain_req) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // Uses post-retire counts so a final writeback completes the
               // drain on the very next cycle
               if (&w_next_zero) begin
                  r_state      <= DONE;
                  r_drain_done <= 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            IDLE: begin
               if (!drain_req) begin
                  r_state <= RUN;
               end
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

`ifdef SB_PERF_EN
   logic [15:0] r_stall_cnt;

   // Counts cycles where decode offers an instruction but hazards hold it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (issue_valid && !issue_ready && (r_state == RUN) &&
                   (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Brief    : Directed-vector bench for reg_scoreboard. Stimulus queues the
//             expected output value for a given cycle; a negedge monitor pops
//             and compares entries due in the current cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    localparam int K_READY = 0;
    localparam int K_BUSY  = 1;
    localparam int K_ERR   = 2;
    localparam int K_DONE  = 3;
    localparam int K_STALL = 4;

`ifdef SB_PERF_EN
    localparam logic [15:0] c_exp_stall = 16'd10;
`else
    localparam logic [15:0] c_exp_stall = 16'd0;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        int          tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic        wbE_valid, wbM_valid;
    logic [3:0]  wbE_reg, wbM_reg;
    logic        drain_req;
    logic        drain_done;
    logic [14:0] busy_mask;
    logic        err;
    logic [15:0] stall_cnt;

    int   cyc     = 0;
    int   step_id = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t sb_q[$];

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .srcA        (srcA),
        .srcB        (srcB),
        .dstE        (dstE),
        .dstM        (dstM),
        .wbE_valid   (wbE_valid),
        .wbE_reg     (wbE_reg),
        .wbM_valid   (wbM_valid),
        .wbM_reg     (wbM_reg),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .busy_mask   (busy_mask),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to schedule expectations
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_READY: return "issue_ready";
            K_BUSY:  return "busy_mask";
            K_ERR:   return "err";
            K_DONE:  return "drain_done";
            default: return "stall_cnt";
        endcase
    endfunction

    function automatic logic [15:0] actual(input int k);
        case (k)
            K_READY: return {15'd0, issue_ready};
            K_BUSY:  return {1'b0, busy_mask};
            K_ERR:   return {15'd0, err};
            K_DONE:  return {15'd0, drain_done};
            default: return stall_cnt;
        endcase
    endfunction

    // Monitor: compare every expectation scheduled for the current cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                checks++;
                if (actual(sb_q[i].kind) !== sb_q[i].exp) begin
                    errors++;
                    $display("FAIL %s step%0d cyc%0d: got %h expected %h",
                             kname(sb_q[i].kind), sb_q[i].tag, cyc,
                             actual(sb_q[i].kind), sb_q[i].exp);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int k, input logic [15:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        e.tag  = step_id;
        sb_q.push_back(e);
    endtask

    task automatic idle_in();
        issue_valid = 1'b0;
        srcA = 4'hF; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF;
        wbE_valid = 1'b0; wbE_reg = 4'hF;
        wbM_valid = 1'b0; wbM_reg = 4'hF;
    endtask

    task automatic wb_e(input logic [3:0] r);
        wbE_valid = 1'b1; wbE_reg = r;
    endtask

    task automatic wb_m(input logic [3:0] r);
        wbM_valid = 1'b1; wbM_reg = r;
    endtask

    initial begin
        idle_in();
        drain_req = 1'b0;
        rst_n     = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        step_id = 1;
        exp_at(K_READY, 16'd1); exp_at(K_BUSY, 16'd0); exp_at(K_ERR, 16'd0);
        exp_at(K_DONE, 16'd0);  exp_at(K_STALL, 16'd0);
        tick();
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready after reset: got %b expected 1", issue_ready);
        end
        checks++;
        if (busy_mask !== 15'd0) begin
            errors++;
            $display("FAIL busy_mask after reset: got %h expected 0", busy_mask);
        end

        // irmovq r3, then dependent OPq stalls until wb r3
        step_id = 2;
        issue_valid = 1'b1; dstE = 4'd3;
        exp_at(K_READY, 16'd1);
        tick();
        step_id = 3;
        exp_at(K_BUSY, 16'h0008);
        srcA = 4'd3; dstE = 4'd6;
        exp_at(K_READY, 16'd0);
        tick();
        exp_at(K_READY, 16'd0);
        tick();
        wb_e(4'd3);
        exp_at(K_READY, 16'd0);            // no same-cycle bypass
        tick();
        wbE_valid = 1'b0;
        exp_at(K_READY, 16'd1); exp_at(K_BUSY, 16'd0);
        tick();                             // OPq fires, r6 pending
        idle_in();
        exp_at(K_BUSY, 16'h0040);
        wb_e(4'd6);
        tick();
        idle_in();
        exp_at(K_BUSY, 16'd0);

        // popq dstE=dstM=4: two pending writes
        step_id = 4;
        issue_valid = 1'b1; dstE = 4'd4; dstM = 4'd4;
        exp_at(K_READY, 16'd1);
        tick();
        idle_in();
        exp_at(K_BUSY, 16'h0010);
        wb_e(4'd4);
        tick();
        idle_in();
        exp_at(K_BUSY, 16'h0010);
        wb_m(4'd4);
        tick();
        idle_in();
        exp_at(K_BUSY, 16'd0);
        issue_valid = 1'b1; dstE = 4'd4; dstM = 4'd4;
        tick();
        idle_in();
        wb_e(4'd4); wb_m(4'd4);            // both ports retire r4 together
        exp_at(K_BUSY, 16'h0010);
        tick();
        idle_in();
        exp_at(K_BUSY, 16'd0);

        // Saturation on r7 (max 3 in flight)
        step_id = 5;
        issue_valid = 1'b1; dstE = 4'd7;
        exp_at(K_READY, 16'd1); tick();
        exp_at(K_READY, 16'd1); tick();
        exp_at(K_READY, 16'd1); tick();    // cnt7 = 3
        exp_at(K_BUSY, 16'h0080);
        exp_at(K_READY, 16'd0);
        tick();
        wb_e(4'd7);
        exp_at(K_READY, 16'd0);
        tick();                             // cnt7 = 2
        wbE_valid = 1'b0;
        exp_at(K_READY, 16'd1);
        tick();                             // cnt7 = 3
        idle_in();
        wb_e(4'd7); wb_m(4'd7);
        tick();                             // cnt7 = 1
        idle_in();
        issue_valid = 1'b1; dstE = 4'd7; wb_e(4'd7);
        exp_at(K_READY, 16'd1);
        tick();                             // fire + retire: cnt7 stays 1
        idle_in();
        exp_at(K_BUSY, 16'h0080);
        issue_valid = 1'b1; dstE = 4'd7;
        exp_at(K_READY, 16'd1);
        tick();                             // cnt7 = 2
        dstM = 4'd7;                        // would add 2 -> 4 > 3
        exp_at(K_READY, 16'd0);
        wb_e(4'd7); wb_m(4'd7);
        tick();                             // cnt7 = 0
        idle_in();
        dstE = 4'd7; dstM = 4'd7;
        exp_at(K_READY, 16'd1); exp_at(K_BUSY, 16'd0);
        tick();
        idle_in();

        // Retire to an idle register sets sticky err
        step_id = 6;
        exp_at(K_ERR, 16'd0);
        wb_e(4'd5);
        tick();
        idle_in();
        exp_at(K_ERR, 16'd1); exp_at(K_BUSY, 16'd0);
        tick();
        tick();
        exp_at(K_ERR, 16'd1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err not sticky: got %b expected 1", err);
        end

        // Drain with r2 pending; final retire completes drain
        step_id = 7;
        issue_valid = 1'b1; dstE = 4'd2;
        tick();
        idle_in();
        drain_req = 1'b1;
        exp_at(K_READY, 16'd1); exp_at(K_DONE, 16'd0);
        tick();                             // DRAIN
        exp_at(K_READY, 16'd0); exp_at(K_DONE, 16'd0);
        tick();
        exp_at(K_READY, 16'd0); exp_at(K_DONE, 16'd0);
        wb_e(4'd2);
        tick();                             // DONE
        idle_in();
        exp_at(K_DONE, 16'd1); exp_at(K_BUSY, 16'd0); exp_at(K_READY, 16'd0);
        tick();                             // IDLE
        exp_at(K_DONE, 16'd0); exp_at(K_READY, 16'd0);
        tick();
        exp_at(K_READY, 16'd0);
        drain_req = 1'b0;
        tick();                             // RUN
        exp_at(K_READY, 16'd1); exp_at(K_DONE, 16'd0);

        // Drain with all counters already zero
        step_id = 8;
        drain_req = 1'b1;
        tick();                             // DRAIN
        exp_at(K_DONE, 16'd0); exp_at(K_READY, 16'd0);
        tick();                             // DONE
        exp_at(K_DONE, 16'd1);
        drain_req = 1'b0;
        tick();                             // IDLE
        exp_at(K_DONE, 16'd0); exp_at(K_READY, 16'd0);
        tick();                             // RUN
        exp_at(K_READY, 16'd1);

        // Reset asserted mid-drain
        step_id = 9;
        issue_valid = 1'b1; dstE = 4'd9;
        tick();
        idle_in();
        drain_req = 1'b1;
        tick();                             // DRAIN, r9 pending
        exp_at(K_READY, 16'd0);
        tick();
        rst_n = 1'b0; drain_req = 1'b0;
        exp_at(K_READY, 16'd1); exp_at(K_BUSY, 16'd0); exp_at(K_ERR, 16'd0);
        exp_at(K_DONE, 16'd0);  exp_at(K_STALL, 16'd0);
        tick();
        exp_at(K_DONE, 16'd0);
        tick();
        rst_n = 1'b1;
        exp_at(K_READY, 16'd1); exp_at(K_DONE, 16'd0);
        tick();

        // Ten stalled cycles on r1
        step_id = 10;
        issue_valid = 1'b1; dstE = 4'd1;
        exp_at(K_READY, 16'd1);
        tick();
        dstE = 4'hF; srcA = 4'd1;
        for (int n = 0; n < 10; n++) begin
            exp_at(K_READY, 16'd0);
            tick();
        end
        idle_in();
        exp_at(K_STALL, c_exp_stall);
        wb_e(4'd1);
        tick();
        idle_in();
        exp_at(K_BUSY, 16'd0); exp_at(K_STALL, c_exp_stall);
        repeat (3) tick();

        // Anything still queued was never compared
        while (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked %s step%0d: got none expected %h",
                     kname(sb_q[0].kind), sb_q[0].tag, sb_q[0].exp);
            void'(sb_q.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
